// File: rtl/m68k_bus_initiator.sv
// m68k_bus_initiator
//   68000-style bus cycle initiator. A request/done handshake on the user side
//   is turned into an asynchronous-bus read or write cycle (nAS, nUDS/nLDS, RW,
//   address, data), terminated by nDTACK or by a wait-state timeout.
//
// Ports
//   CLK_68KCLK  in   sole clock, every output is a register on its rising edge
//   RESET       in   synchronous active-high reset (aborts any cycle, no DONE)
//   REQ         in   request, accepted when REQ=1 and BUSY=0
//   REQ_ADDR    in   word address A[23:1], captured at accept
//   REQ_WE      in   1=write, 0=read, captured at accept
//   REQ_BE      in   byte enables {upper,lower}, captured at accept
//   REQ_WDATA   in   write data, captured at accept
//   BUSY        out  high in every state except IDLE
//   DONE        out  one-cycle pulse at the end of a bus cycle
//   ERR         out  valid with DONE: timeout or empty byte-enable request
//   RDATA       out  read data (unselected lanes zero), valid from DONE
//   M68K_ADDR   out  bus address A[23:1]
//   M68K_DOUT   out  bus write data (byte writes duplicated on both lanes)
//   DATA_OE     out  drive M68K_DOUT onto the bus
//   M68K_DIN    in   bus read data
//   RW          out  1=read, 0=write
//   nAS         out  address strobe, active low
//   nUDS, nLDS  out  data strobes, active low
//   nDTACK      in   acknowledge, synchronous to CLK_68KCLK
module m68k_bus_initiator #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK_68KCLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [22:0] REQ_ADDR,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_BE,
  input  logic [15:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [22:0] M68K_ADDR,
  output logic [15:0] M68K_DOUT,
  output logic        DATA_OE,
  input  logic [15:0] M68K_DIN,
  output logic        RW,
  output logic        nAS,
  output logic        nUDS,
  output logic        nLDS,
  input  logic        nDTACK
);

  localparam int              CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASSERT, S_WDS, S_WAIT, S_LATCH, S_NEGATE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_we;
  logic [1:0]      r_be;
  logic [CW-1:0]   r_wait_cnt;

  // output registers
  logic            r_busy, r_done, r_err, r_data_oe, r_rw, r_nas, r_nuds, r_nlds;
  logic [15:0]     r_rdata, r_dout;
  logic [22:0]     r_addr;

  // next values of the output registers
  logic            w_busy_next, w_done_next, w_err_next, w_data_oe_next;
  logic            w_rw_next, w_nas_next, w_nuds_next, w_nlds_next;
  logic [15:0]     w_rdata_next, w_dout_next;
  logic [22:0]     w_addr_next;

  logic            w_accept;
  logic            w_we;
  logic [1:0]      w_be;
  logic            w_ds_on;
  logic [15:0]     w_din_masked;

  assign w_accept = (r_state == S_IDLE) && REQ;
  // Request attributes as seen by the cycle that starts on this edge.
  assign w_we     = w_accept ? REQ_WE : r_we;
  assign w_be     = w_accept ? REQ_BE : r_be;

  // Byte lanes that were not requested read back as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign w_din_masked[gi*8 +: 8] = r_be[gi] ? M68K_DIN[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // A single-byte write puts the selected byte on both lanes so the target
  // sees valid data whichever lane it decodes.
  function automatic logic [15:0] lane_dup(input logic [1:0] be, input logic [15:0] d);
    case (be)
      2'b01:   lane_dup = {d[7:0], d[7:0]};
      2'b10:   lane_dup = {d[15:8], d[15:8]};
      default: lane_dup = d;
    endcase
  endfunction

  // State register, request capture and wait counter
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_be       <= 2'b00;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we <= REQ_WE;
        r_be <= REQ_BE;
      end
      // Counts from zero in the first WAIT cycle.
      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                   r_wait_cnt <= '0;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (REQ) w_state_next = S_ADDR;
      S_ADDR:   w_state_next = (r_be == 2'b00) ? S_NEGATE : S_ASSERT;
      S_ASSERT: w_state_next = r_we ? S_WDS : S_WAIT;
      S_WDS:    w_state_next = S_WAIT;
      S_WAIT: begin
        if (!nDTACK)                       w_state_next = S_LATCH;
        else if (r_wait_cnt == LAST_WAIT)  w_state_next = S_NEGATE;
      end
      S_LATCH:  w_state_next = S_NEGATE;
      S_NEGATE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output decode from the state being entered, so registered outputs line up
  // with the state they belong to.
  always_comb begin
    w_busy_next    = (w_state_next != S_IDLE);
    w_done_next    = (w_state_next == S_NEGATE);
    // NEGATE is reached from ADDR only for BE=00 and from WAIT only on timeout.
    w_err_next     = (w_state_next == S_NEGATE) &&
                     ((r_state == S_ADDR) || (r_state == S_WAIT));
    w_rw_next      = (w_state_next == S_IDLE) ? 1'b1 : ~w_we;
    w_data_oe_next = (w_state_next != S_IDLE) && w_we;
    w_nas_next     = !((w_state_next == S_ASSERT) || (w_state_next == S_WDS) ||
                       (w_state_next == S_WAIT)   || (w_state_next == S_LATCH));
    // Reads assert data strobes together with nAS, writes one cycle later.
    w_ds_on        = (w_state_next == S_WAIT) || (w_state_next == S_LATCH) ||
                     (w_state_next == S_WDS)  ||
                     ((w_state_next == S_ASSERT) && !w_we);
    w_nuds_next    = !(w_ds_on && w_be[1]);
    w_nlds_next    = !(w_ds_on && w_be[0]);
    w_addr_next    = w_accept ? REQ_ADDR : r_addr;
    w_dout_next    = (w_accept && REQ_WE) ? lane_dup(REQ_BE, REQ_WDATA) : r_dout;
    w_rdata_next   = ((r_state == S_LATCH) && !r_we) ? w_din_masked : r_rdata;
  end

  // Output registers
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rw      <= 1'b1;
      r_data_oe <= 1'b0;
      r_nas     <= 1'b1;
      r_nuds    <= 1'b1;
      r_nlds    <= 1'b1;
      r_addr    <= '0;
      r_dout    <= '0;
      r_rdata   <= '0;
    end else begin
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
      r_rw      <= w_rw_next;
      r_data_oe <= w_data_oe_next;
      r_nas     <= w_nas_next;
      r_nuds    <= w_nuds_next;
      r_nlds    <= w_nlds_next;
      r_addr    <= w_addr_next;
      r_dout    <= w_dout_next;
      r_rdata   <= w_rdata_next;
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR       = r_err;
  assign RDATA     = r_rdata;
  assign M68K_ADDR = r_addr;
  assign M68K_DOUT = r_dout;
  assign DATA_OE   = r_data_oe;
  assign RW        = r_rw;
  assign nAS       = r_nas;
  assign nUDS      = r_nuds;
  assign nLDS      = r_nlds;

endmodule
